fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch (IF) stage of the 5-stage MIPS32 pipeline, directly upstream of the ID-stage main control and register file.
- Owns the PC and runs a single-outstanding request/response handshake with instruction memory.
- Drives the IF/ID pipeline register whose `if_id_instr[31:26]` feeds the main control's `opcode` input.
- Honours stalls from the ID-stage hazard unit and PC redirects from the branch unit.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  from ID hazard unit; hold PC and IF/ID.
- `branch_taken`  in  1  redirect request; one-cycle pulse.
- `branch_target`  in  32  redirect address; bits [1:0] ignored, forced to 0.
- `imem_req`  out  1  request valid; memory accepts in the same cycle.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_rvalid`  in  1  response valid, at least 1 cycle after the request.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `pc`  out  32  current fetch PC.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_instr`  out  32  IF/ID instruction; 32'h0 (sll nop) when not valid.
- `if_id_pc4`  out  32  address of the IF/ID instruction + 4.

## Operation
FSM states:
- **FETCH**
  - Asserts `imem_req`, with `imem_addr` = `pc`.
  - Next state WAIT, unless `branch_taken`.
- **WAIT**
  - `imem_req`=0; waits for `imem_rvalid`.
  - On `imem_rvalid` with `squash`=1: drop the word, clear `squash`, go to FETCH.
  - On `imem_rvalid` with `stall`=0: load IF/ID with {1, `imem_rdata`, `pc`+4}, set `pc` ← `pc`+4, go to FETCH.
  - On `imem_rvalid` with `stall`=1: capture the word in a skid buffer, go to FULL.
- **FULL**
  - `imem_req`=0.
  - When `stall`=0: load IF/ID from the buffer, set `pc` ← `pc`+4, go to FETCH.

Rules that apply in every state:
- **IF/ID load priority:** `branch_taken` flush > `stall` hold > new instruction load > bubble.
- **Bubble:** with no instruction delivered and `stall`=0, IF/ID gets {0, 32'h0, 32'h0}.
- **`branch_taken`:**
  - `pc` ← {`branch_target`[31:2], 2'b00}.
  - IF/ID is flushed to bubble even if `stall`=1.
  - Any buffered word is discarded.
  - From FETCH or FULL: next state FETCH.
  - From WAIT without `imem_rvalid`: stay in WAIT with `squash` ← 1.
  - From WAIT with `imem_rvalid` in the same cycle: the word is dropped, next state FETCH.
- **`squash` in WAIT:** `squash` remains set until the stale response arrives. It is never cleared by `stall`.
- **`stall` in FETCH:** does not block the request; only delivery waits.
- **Arithmetic:** `pc`+4 is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 32'h0 with no flag.
- **Protocol assumption:** `imem_rvalid` outside WAIT is a protocol violation. It is ignored; the bench flags it.

## Timing
- **Reset values:** `pc`=`RESET_PC`, state FETCH, `squash`=0, buffer=0, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc4`=0. `imem_req`=0 while `reset`=0.
- **Reset release:** first `imem_req`=1 in the first cycle after deassertion.
- **Reset mid-operation:** aborts everything immediately, asynchronously. A response arriving after reset is released is ignored, because the FSM is in FETCH.
- **Latency:** with 1-cycle memory, an instruction appears in IF/ID 2 cycles after its request edge.
- **Throughput:** peak throughput is one instruction per 2 cycles.
- **Outputs:** `imem_req` and `imem_addr` are Moore outputs of state and `pc`. All IF/ID outputs are registered.

## Structure
- `constants.h` additions:
  - `` `NOP `` = 32'h0.
  - `` `RESET_PC_DEFAULT ``.
  - FSM encodings `` `IF_FETCH `` = 2'b00, `` `IF_WAIT `` = 2'b01, `` `IF_FULL `` = 2'b10.
- Sub-module `if_id_reg`:
  - Holds valid, instr and pc4 with async active-low reset.
  - Priority inputs: flush, hold, load.
  - Reused as the template for the later ID/EX register.
- FSM, PC, squash and skid buffer stay in `fetch_stage`.

## Test plan
- **Reset and straight-line fetch.** 1-cycle memory returns words 0x20080005, 0x20090003, 0x01095020 at 0x0, 0x4, 0x8 → IF/ID shows them in order with `if_id_pc4` = 0x4, 0x8, 0xC, each valid for one cycle, separated by bubble cycles.
- **Stall during WAIT.** `stall`=1 on the cycle `imem_rvalid` returns 0x8C0B0000 → FSM goes to FULL and IF/ID holds its prior content. On `stall`=0, IF/ID gets 0x8C0B0000, then `imem_req` rises with the next address.
- **Squash.** `branch_taken`=1 with target 0x40 while in WAIT, memory slow (3 cycles) → stale word dropped, no valid IF/ID. The next `imem_addr` is 0x40 and delivers `if_id_pc4` = 0x44.
- **Coincident events.**
  - `branch_taken` together with `imem_rvalid` and `stall` → IF/ID flushed to 0 and `pc`=target.
  - A target of 0x43 produces `imem_addr` 0x40.
- **Wrap-around.** `RESET_PC` = 32'hFFFF_FFFC → after the first delivery, `pc`=0, `if_id_pc4`=0, and the next request goes to 0x0.
- **Reset mid-operation.** Assert `reset` low while in WAIT, release, then a late `imem_rvalid` arrives → all outputs at reset values, late response ignored, refetch from `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and types for the IF stage.
//   NOP              - instruction word placed in IF/ID when it holds no instruction
//   RESET_PC_DEFAULT - default fetch address after reset
//   if_state_t       - fetch FSM state encoding
//   word_align()     - clears the byte-offset bits of an address
package fetch_stage_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_FETCH = 2'b00,
    IF_WAIT  = 2'b01,
    IF_FULL  = 2'b10
  } if_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register (valid, instruction, pc+4).
// Ports:
//   clock, reset       - clock, asynchronous active-low reset
//   flush, hold, load  - update controls, in that priority order; with none
//                        of them active the register takes a bubble
//   load_instr/pc4     - contents written when load wins
//   valid, instr, pc4  - registered outputs; instr is NOP whenever valid=0
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= NOP;
      pc4   <= 32'h0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP;
      pc4   <= 32'h0;
    end else if (!hold) begin
      if (load) begin
        valid <= 1'b1;
        instr <= load_instr;
        pc4   <= load_pc4;
      end else begin
        valid <= 1'b0;
        instr <= NOP;
        pc4   <= 32'h0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS32 instruction-fetch stage. Owns the PC, keeps at most one
// request outstanding to instruction memory and feeds the IF/ID register.
// Ports:
//   clock, reset                 - clock, asynchronous active-low reset
//   stall                        - ID hazard unit: hold PC and IF/ID
//   branch_taken, branch_target  - one-cycle redirect pulse and its address
//   imem_req, imem_addr          - request (accepted in the same cycle)
//   imem_rvalid, imem_rdata      - response, at least one cycle later
//   pc                           - current fetch PC
//   if_id_valid/instr/pc4        - registered IF/ID contents
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  if_state_t   state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        squash_reg, squash_next;
  logic [31:0] skid_reg, skid_next;

  logic        load;
  logic [31:0] load_instr;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc_reg + 32'd4;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= IF_FETCH;
      pc_reg     <= RESET_PC;
      squash_reg <= 1'b0;
      skid_reg   <= 32'h0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      squash_reg <= squash_next;
      skid_reg   <= skid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    squash_next = squash_reg;
    skid_next   = skid_reg;
    load        = 1'b0;
    load_instr  = skid_reg;

    case (state_reg)
      IF_FETCH: begin
        // Stall does not block the request; only delivery waits.
        state_next = IF_WAIT;
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          if (branch_taken || squash_reg) begin
            // Response belongs to a fetch that was redirected away.
            squash_next = 1'b0;
            state_next  = IF_FETCH;
          end else if (!stall) begin
            load       = 1'b1;
            load_instr = imem_rdata;
            pc_next    = pc_plus4;
            state_next = IF_FETCH;
          end else begin
            skid_next  = imem_rdata;
            state_next = IF_FULL;
          end
        end else if (branch_taken) begin
          // Keep waiting so the stale response is consumed, not mistaken
          // for the word at the new target.
          squash_next = 1'b1;
        end
      end
      IF_FULL: begin
        if (!stall) begin
          load       = 1'b1;
          pc_next    = pc_plus4;
          state_next = IF_FETCH;
        end
      end
      default: state_next = IF_FETCH;
    endcase

    // Redirect overrides every state except an unanswered WAIT.
    if (branch_taken) begin
      pc_next   = word_align(branch_target);
      skid_next = 32'h0;
      load      = 1'b0;
      if (state_reg != IF_WAIT || imem_rvalid) begin
        state_next = IF_FETCH;
      end
    end
  end

  // imem_req is gated by reset so nothing is requested while reset is held.
  assign imem_req  = reset && (state_reg == IF_FETCH);
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;

  if_id_reg u_if_id (
    .clock      (clock),
    .reset      (reset),
    .flush      (branch_taken),
    .hold       (stall),
    .load       (load),
    .load_instr (load_instr),
    .load_pc4   (pc_plus4),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .pc4        (if_id_pc4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4)
  );

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit verbose = 1'b1;

  // Reference model: one fetch in flight at most, words waiting for the
  // stall to drop sit in a queue, a stale flag marks a redirected fetch.
  bit          in_flight;
  bit          stale;
  logic [31:0] pending[$];
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  // Memory model state.
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;
  bit          inject_late;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0003;
      32'h0000_0008: return 32'h0109_5020;
      32'h0000_000C: return 32'h8C0B_0000;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_init();
    in_flight = 1'b0;
    stale     = 1'b0;
    pending.delete();
    m_pc      = RST_PC;
    m_valid   = 1'b0;
    m_instr   = 32'h0;
    m_pc4     = 32'h0;
  endtask

  task automatic model_bubble();
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (!reset) begin
      model_init();
    end else if (branch_taken) begin
      model_bubble();
      m_pc = branch_target & 32'hFFFF_FFFC;
      pending.delete();
      if (in_flight && !imem_rvalid) stale = 1'b1;
      else begin
        in_flight = 1'b0;
        stale     = 1'b0;
      end
    end else begin
      if (!in_flight && pending.size() == 0) begin
        in_flight = 1'b1;
      end else if (in_flight && imem_rvalid) begin
        in_flight = 1'b0;
        if (stale) stale = 1'b0;
        else pending.push_back(imem_rdata);
      end
      if (!stall) begin
        if (pending.size() != 0) begin
          w       = pending.pop_front();
          m_valid = 1'b1;
          m_instr = w;
          m_pc4   = m_pc + 32'd4;
          m_pc    = m_pc + 32'd4;
          if (verbose) $display("tx cycle=%0d instr=%h pc4=%h", cyc, m_instr, m_pc4);
        end else begin
          model_bubble();
        end
      end
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = reset && !in_flight && (pending.size() == 0);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc4", if_id_pc4, m_pc4);
  endtask

  // One clock: compare on the falling edge, drive inputs and memory,
  // then advance the model on the rising edge.
  task automatic cycle(input bit st, input bit br, input logic [31:0] tgt, input int lat);
    @(negedge clock);
    compare();
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_rvalid   = 1'b0;
    imem_rdata    = $urandom;
    if (inject_late) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      inject_late = 1'b0;
    end else if (mem_busy) begin
      mem_wait--;
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_busy    = 1'b0;
      end
    end
    // A request coinciding with a redirect is treated as cancelled.
    if (imem_req === 1'b1 && !br) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_wait = lat;
    end
    @(posedge clock);
    model_step();
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    check({tag, "_instr"}, if_id_instr, 32'h0);
    check({tag, "_pc4"}, if_id_pc4, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mem_busy = 1'b0; mem_wait = 0; mem_addr = 32'h0; inject_late = 1'b0;
    model_init();

    repeat (2) @(posedge clock);
    #1 check_reset_outputs("reset");
    #1 reset = 1'b1;

    // Straight-line fetch, 1-cycle memory.
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #1 check("sl0_valid", {31'b0, if_id_valid}, 32'h1);
    check("sl0_instr", if_id_instr, 32'h2008_0005);
    check("sl0_pc4", if_id_pc4, 32'h4);
    check("sl0_model", m_instr, 32'h2008_0005);
    cycle(0, 0, 0, 1);
    #1 check("sl_bubble", {31'b0, if_id_valid}, 32'h0);
    cycle(0, 0, 0, 1);
    #1 check("sl1_instr", if_id_instr, 32'h2009_0003);
    check("sl1_pc4", if_id_pc4, 32'h8);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #1 check("sl2_instr", if_id_instr, 32'h0109_5020);
    check("sl2_pc4", if_id_pc4, 32'hC);

    // Stall while the response returns: skid buffer holds it.
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    #1 check("full_req", {31'b0, imem_req}, 32'h0);
    check("full_hold_instr", if_id_instr, 32'h0109_5020);
    check("full_hold_valid", {31'b0, if_id_valid}, 32'h1);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #1 check("skid_instr", if_id_instr, 32'h8C0B_0000);
    check("skid_pc4", if_id_pc4, 32'h10);
    check("skid_next_req", {31'b0, imem_req}, 32'h1);
    check("skid_next_addr", imem_addr, 32'h10);

    // Redirect while waiting on a 3-cycle memory.
    cycle(0, 0, 0, 3);
    cycle(0, 1, 32'h40, 3);
    #1 check("sq_pc", pc, 32'h40);
    check("sq_valid", {31'b0, if_id_valid}, 32'h0);
    check("sq_req", {31'b0, imem_req}, 32'h0);
    cycle(0, 0, 0, 3);
    cycle(0, 0, 0, 1);
    #1 check("sq_drop_valid", {31'b0, if_id_valid}, 32'h0);
    check("sq_addr", imem_addr, 32'h40);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #1 check("sq_pc4", if_id_pc4, 32'h44);
    check("sq_valid2", {31'b0, if_id_valid}, 32'h1);

    // Redirect coinciding with response and stall, unaligned target.
    cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h43, 1);
    #1 check("co_valid", {31'b0, if_id_valid}, 32'h0);
    check("co_instr", if_id_instr, 32'h0);
    check("co_pc", pc, 32'h40);
    check("co_addr", imem_addr, 32'h40);
    check("co_req", {31'b0, imem_req}, 32'h1);

    // Reset while waiting, then a late response after release.
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 3);
    cycle(1, 0, 0, 3);
    #2 reset = 1'b0;
    mem_busy = 1'b0;
    model_init();
    #1 check_reset_outputs("midrst");
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #2 reset = 1'b1;
    inject_late = 1'b1;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #1 check("late_instr", if_id_instr, 32'h2008_0005);
    check("late_pc4", if_id_pc4, 32'h4);

    // Wrap-around of pc+4.
    cycle(0, 1, 32'hFFFF_FFFF, 1);
    #1 check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #1 check("wrap_pc", pc, 32'h0);
    check("wrap_pc4", if_id_pc4, 32'h0);
    check("wrap_valid", {31'b0, if_id_valid}, 32'h1);
    check("wrap_addr0", imem_addr, 32'h0);

    // Randomized traffic checked against the model every cycle.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, tgt, $urandom_range(1, 4));
    end

    @(negedge clock);
    compare();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
